// File: rtl/apb_irq_ctrl_if.sv
// APB slave bus bundle for apb_irq_ctrl: 8-bit address/data, single strobe bit.
interface apb_irq_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pstrb;
  logic [7:0] prdata;
  logic       pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready
  );
endinterface

// File: rtl/apb_irq_ctrl.sv
// 8-source interrupt controller with per-bit mask, level/edge mode, polarity and claim.
// Optional macro APB_IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every source bit.
module apb_irq_ctrl (
  input  logic                 aclk,
  input  logic                 rst,
  apb_irq_ctrl_if.slave        apb,
  input  logic [7:0]           irq_src,
  output logic                 irq_o
);

  localparam logic [3:0] A_STATUS = 4'h0;
  localparam logic [3:0] A_MASK   = 4'h1;
  localparam logic [3:0] A_EDGE   = 4'h2;
  localparam logic [3:0] A_POL    = 4'h3;
  localparam logic [3:0] A_MPEND  = 4'h4;
  localparam logic [3:0] A_CLAIM  = 4'h5;

  logic [7:0] r_status, r_mask, r_edge, r_pol, r_cond_d;
  logic       r_irq;
  logic [7:0] w_s, w_cond, w_rise, w_clr, w_status_nxt, w_mpend, w_claim, w_rdata;
  logic [3:0] w_addr;
  logic       w_wr;
  logic       w_unused_addr;

`ifdef APB_IRQ_CTRL_SYNC_EN
  logic [7:0] r_sync1, r_sync2;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = irq_src;
`endif

  assign w_addr        = apb.paddr[3:0];
  assign w_unused_addr = ^apb.paddr[7:4];
  assign w_wr          = apb.psel & apb.penable & apb.pwrite & apb.pstrb;
  assign w_clr         = (w_wr && (w_addr == A_STATUS)) ? apb.pwdata : 8'h00;

  assign w_cond  = w_s ^ r_pol;
  assign w_rise  = w_cond & ~r_cond_d;
  assign w_mpend = r_status & r_mask;

  // Edge bits: a new rise beats a same-cycle W1C; level bits simply follow cond.
  assign w_status_nxt = (r_edge & (w_rise | (r_status & ~w_clr))) | (~r_edge & w_cond);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_status <= 8'h00;
      r_cond_d <= 8'h00;
      r_irq    <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_cond_d <= w_cond;
      r_irq    <= |w_mpend;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_mask <= 8'h00;
      r_edge <= 8'h00;
      r_pol  <= 8'h00;
    end else if (w_wr) begin
      case (w_addr)
        A_MASK:  r_mask <= apb.pwdata;
        A_EDGE:  r_edge <= apb.pwdata;
        A_POL:   r_pol  <= apb.pwdata;
        default: ;
      endcase
    end
  end

  // Lowest-numbered pending bit wins, so scan from the top down.
  always_comb begin
    w_claim = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (w_mpend[i]) begin
        w_claim = {1'b1, 4'b0000, i[2:0]};
      end else begin
        w_claim = w_claim;
      end
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (apb.psel && !apb.pwrite) begin
      case (w_addr)
        A_STATUS: w_rdata = r_status;
        A_MASK:   w_rdata = r_mask;
        A_EDGE:   w_rdata = r_edge;
        A_POL:    w_rdata = r_pol;
        A_MPEND:  w_rdata = w_mpend;
        A_CLAIM:  w_rdata = w_claim;
        default:  w_rdata = 8'h00;
      endcase
    end else begin
      w_rdata = 8'h00;
    end
  end

  assign apb.prdata = w_rdata;
  assign apb.pready = 1'b1;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed self-checking bench for apb_irq_ctrl; honours APB_IRQ_CTRL_SYNC_EN latency.
module tb_apb_irq_ctrl;

`ifdef APB_IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       aclk;
  logic       rst;
  logic [7:0] irq_src;
  logic       irq_o;
  int         n_tests;
  int         n_fail;

  apb_irq_ctrl_if bus ();

  apb_irq_ctrl dut (
    .aclk    (aclk),
    .rst     (rst),
    .apb     (bus.slave),
    .irq_src (irq_src),
    .irq_o   (irq_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [7:0] d, input logic s);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = a;
    bus.pwdata  = d;
    bus.pstrb   = s;
    @(negedge aclk);
    bus.penable = 1'b1;
    @(negedge aclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pstrb   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = a;
    #1;
    d        = bus.prdata;
    bus.psel = 1'b0;
    check_val(tag, d, exp);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    irq_src     = 8'h00;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 8'h00;
    bus.pwdata  = 8'h00;
    bus.pstrb   = 1'b0;
    repeat (3) @(negedge aclk);

    check_val("rst_irq", {7'd0, irq_o}, 8'h00);
    check_val("rst_pready", {7'd0, bus.pready}, 8'h01);
    check_val("rst_prdata_idle", bus.prdata, 8'h00);
    rd_chk("rst_status", 8'h00, 8'h00);
    rst = 1'b0;
    @(negedge aclk);

    // Level mode propagation and fall
    apb_wr(8'h01, 8'h01, 1'b1);
    irq_src = 8'h01;
    repeat (SYNC_LAT) @(negedge aclk);
    @(negedge aclk);
    rd_chk("lvl_status", 8'h00, 8'h01);
    check_val("lvl_irq_lag", {7'd0, irq_o}, 8'h00);
    @(negedge aclk);
    check_val("lvl_irq", {7'd0, irq_o}, 8'h01);
    irq_src = 8'h00;
    repeat (SYNC_LAT) @(negedge aclk);
    @(negedge aclk);
    rd_chk("lvl_status_fall", 8'h00, 8'h00);
    check_val("lvl_irq_hold", {7'd0, irq_o}, 8'h01);
    @(negedge aclk);
    check_val("lvl_irq_fall", {7'd0, irq_o}, 8'h00);

    // Edge mode capture, claim and W1C
    apb_wr(8'h01, 8'h04, 1'b1);
    apb_wr(8'h02, 8'h04, 1'b1);
    irq_src = 8'h04;
    @(negedge aclk);
    irq_src = 8'h00;
    repeat (SYNC_LAT + 1) @(negedge aclk);
    rd_chk("edge_status", 8'h00, 8'h04);
    rd_chk("edge_claim", 8'h05, 8'h82);
    check_val("edge_irq", {7'd0, irq_o}, 8'h01);
    apb_wr(8'h00, 8'h04, 1'b1);
    rd_chk("edge_w1c", 8'h00, 8'h00);
    check_val("edge_irq_lag", {7'd0, irq_o}, 8'h01);
    @(negedge aclk);
    check_val("edge_irq_fall", {7'd0, irq_o}, 8'h00);

    // Set wins over a same-cycle clear
    apb_wr(8'h02, 8'h06, 1'b1);
    irq_src = 8'h02;
    @(negedge aclk);
    irq_src = 8'h00;
    repeat (SYNC_LAT + 2) @(negedge aclk);
    rd_chk("setwin_pre", 8'h00, 8'h02);
    fork
      begin
        repeat (SYNC_LAT) @(negedge aclk);
        apb_wr(8'h00, 8'h02, 1'b1);
      end
      begin
        @(negedge aclk);
        irq_src = 8'h02;
      end
    join
    rd_chk("setwin", 8'h00, 8'h02);
    irq_src = 8'h00;
    repeat (SYNC_LAT + 1) @(negedge aclk);
    apb_wr(8'h00, 8'h02, 1'b1);
    rd_chk("setwin_clr", 8'h00, 8'h00);

    // Claim priority
    apb_wr(8'h01, 8'h06, 1'b1);
    irq_src = 8'h06;
    @(negedge aclk);
    irq_src = 8'h00;
    repeat (SYNC_LAT + 1) @(negedge aclk);
    rd_chk("claim_mpend", 8'h04, 8'h06);
    rd_chk("claim_b1", 8'h05, 8'h81);
    apb_wr(8'h00, 8'h02, 1'b1);
    rd_chk("claim_b2", 8'h05, 8'h82);
    apb_wr(8'h00, 8'h04, 1'b1);
    rd_chk("claim_none", 8'h05, 8'h00);
    rd_chk("claim_status", 8'h00, 8'h00);

    // Polarity, strobe, decode holes and aliasing
    apb_wr(8'h02, 8'h00, 1'b1);
    apb_wr(8'h01, 8'h00, 1'b1);
    apb_wr(8'h03, 8'h01, 1'b1);
    @(negedge aclk);
    rd_chk("pol_level", 8'h00, 8'h01);
    apb_wr(8'h02, 8'h08, 1'b1);
    apb_wr(8'h03, 8'h09, 1'b1);
    @(negedge aclk);
    rd_chk("pol_edge", 8'h00, 8'h09);
    apb_wr(8'h03, 8'h01, 1'b1);
    @(negedge aclk);
    rd_chk("pol_edge_hold", 8'h00, 8'h09);
    apb_wr(8'h02, 8'h09, 1'b1);
    @(negedge aclk);
    rd_chk("mode_switch_keep", 8'h00, 8'h09);
    apb_wr(8'h00, 8'h01, 1'b1);
    @(negedge aclk);
    rd_chk("mode_switch_noedge", 8'h00, 8'h08);
    apb_wr(8'h03, 8'h00, 1'b0);
    rd_chk("pstrb0_pol", 8'h03, 8'h01);
    rd_chk("hole_0x9", 8'h09, 8'h00);
    rd_chk("alias_pol", 8'hF3, 8'h01);
    rd_chk("edge_reg", 8'h02, 8'h09);

    // Reset in the middle of a write
    apb_wr(8'h01, 8'hFF, 1'b1);
    @(negedge aclk);
    check_val("prerst_irq", {7'd0, irq_o}, 8'h01);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = 8'h01;
    bus.pwdata  = 8'h55;
    bus.pstrb   = 1'b1;
    @(negedge aclk);
    bus.penable = 1'b1;
    rst         = 1'b1;
    #1;
    check_val("rst_async_irq", {7'd0, irq_o}, 8'h00);
    @(negedge aclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pstrb   = 1'b0;
    rd_chk("rst_mask", 8'h01, 8'h00);
    rd_chk("rst_edge", 8'h02, 8'h00);
    rd_chk("rst_pol", 8'h03, 8'h00);
    rd_chk("rst_stat", 8'h00, 8'h00);
    @(negedge aclk);
    rst = 1'b0;
    @(negedge aclk);
    rd_chk("rst_no_commit", 8'h01, 8'h00);
    check_val("post_rst_irq", {7'd0, irq_o}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
